// File: rtl/uart_cmd_decoder_if.sv
// Byte-stream input and register-write / error outputs of the UART command decoder.
interface uart_cmd_decoder_if #(
  parameter int DATA_W = 16
);
  logic [7:0]        din;
  logic              dval_in;
  logic              wr_en_out;
  logic [2:0]        wr_addr_out;
  logic [DATA_W-1:0] wr_data_out;
  logic              err_out;
  logic [1:0]        err_code_out;
  logic              busy_out;

  modport master (
    output din, dval_in,
    input  wr_en_out, wr_addr_out, wr_data_out, err_out, err_code_out, busy_out
  );

  modport slave (
    input  din, dval_in,
    output wr_en_out, wr_addr_out, wr_data_out, err_out, err_code_out, busy_out
  );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Parses ASCII "<letter><digits><CR|LF>" commands from the UART byte stream into
// register write strobes, with error pulses for malformed, oversized, empty or stalled lines.
module uart_cmd_decoder #(
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 400000
) (
  input logic              clk,
  input logic              rst,
  uart_cmd_decoder_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam int EXT_W = DATA_W + 4;

  typedef enum logic [1:0] {IDLE, ADDR, DIGITS, DISCARD} state_t;

  state_t            state;
  logic [DATA_W-1:0] acc;
  logic [2:0]        addr;
  logic [CNT_W-1:0]  cnt;

  logic              wr_en;
  logic [2:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              err;
  logic [1:0]        err_code;
  logic              busy;

  logic              is_letter;
  logic              is_digit;
  logic              is_term;
  logic              is_space;
  logic [2:0]        letter_idx;
  logic [EXT_W-1:0]  acc_ext;
  logic              overflow;
  logic              timeout_hit;

  // 'A'..'H' and 'a'..'h' share low bits 1..7,0, so index = low3 - 1 for both cases
  always_comb begin
    is_letter   = ((bus.din >= 8'h41) && (bus.din <= 8'h48)) ||
                  ((bus.din >= 8'h61) && (bus.din <= 8'h68));
    is_digit    = (bus.din >= 8'h30) && (bus.din <= 8'h39);
    is_term     = (bus.din == 8'h0D) || (bus.din == 8'h0A);
    is_space    = (bus.din == 8'h20);
    letter_idx  = bus.din[2:0] - 3'd1;
    acc_ext     = ({4'b0000, acc} * EXT_W'(10)) + {{(EXT_W-4){1'b0}}, bus.din[3:0]};
    overflow    = acc_ext > {4'b0000, {DATA_W{1'b1}}};
    timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 2));
  end

  // Single registered FSM; strobes default low and pulse for one cycle on the edge that takes the byte
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      acc      <= '0;
      addr     <= '0;
      cnt      <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      err      <= 1'b0;
      err_code <= '0;
      busy     <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      err   <= 1'b0;
      busy  <= (state != IDLE);

      if (bus.dval_in || (state == IDLE)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      if (bus.dval_in) begin
        case (state)
          IDLE: begin
            if (is_letter) begin
              addr  <= letter_idx;
              acc   <= '0;
              state <= ADDR;
            end else if (!(is_term || is_space)) begin
              err      <= 1'b1;
              err_code <= 2'd0;
              state    <= DISCARD;
            end
          end
          ADDR: begin
            if (is_digit) begin
              acc   <= {{(DATA_W-4){1'b0}}, bus.din[3:0]};
              state <= DIGITS;
            end else if (is_term) begin
              err      <= 1'b1;
              err_code <= 2'd2;
              state    <= IDLE;
            end else begin
              err      <= 1'b1;
              err_code <= 2'd0;
              state    <= DISCARD;
            end
          end
          DIGITS: begin
            if (is_digit) begin
              if (overflow) begin
                err      <= 1'b1;
                err_code <= 2'd1;
                state    <= DISCARD;
              end else begin
                acc <= acc_ext[DATA_W-1:0];
              end
            end else if (is_term) begin
              wr_en   <= 1'b1;
              wr_addr <= addr;
              wr_data <= acc;
              state   <= IDLE;
            end else begin
              err      <= 1'b1;
              err_code <= 2'd0;
              state    <= DISCARD;
            end
          end
          DISCARD: begin
            if (is_term) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (timeout_hit && (state != IDLE)) begin
        // A stalled bad line already reported its error, so it times out silently
        if (state != DISCARD) begin
          err      <= 1'b1;
          err_code <= 2'd3;
        end
        state <= IDLE;
      end
    end
  end

  assign bus.wr_en_out    = wr_en;
  assign bus.wr_addr_out  = wr_addr;
  assign bus.wr_data_out  = wr_data;
  assign bus.err_out      = err;
  assign bus.err_code_out = err_code;
  assign bus.busy_out     = busy;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Randomized self-checking bench for uart_cmd_decoder against a line-buffer model of the command grammar.
module tb_uart_cmd_decoder;

  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 300;
  localparam longint MAX_VAL = (longint'(1) << DATA_W) - 1;

  logic clk = 1'b0;
  logic rst;

  uart_cmd_decoder_if #(.DATA_W(DATA_W)) bus();

  uart_cmd_decoder #(
    .DATA_W(DATA_W),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: the letter and digits of the current line, plus a flag for a line already reported bad
  logic [7:0]  line_q[$];
  bit          line_bad;
  logic [31:0] held_addr;
  logic [31:0] held_data;
  logic [31:0] held_code;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_letter(input logic [7:0] b);
    return ((b >= "A") && (b <= "H")) || ((b >= "a") && (b <= "h"));
  endfunction

  function automatic bit is_digit(input logic [7:0] b);
    return (b >= "0") && (b <= "9");
  endfunction

  function automatic bit is_term(input logic [7:0] b);
    return (b == 8'h0D) || (b == 8'h0A);
  endfunction

  function automatic longint line_value();
    longint v = 0;
    for (int i = 1; i < line_q.size(); i++) v = v * 10 + longint'(line_q[i] - "0");
    return v;
  endfunction

  function automatic bit model_busy();
    return line_bad || (line_q.size() > 0);
  endfunction

  // kind: 0 = nothing, 1 = write, 2 = error
  task automatic model_byte(input logic [7:0] b, output int kind);
    kind = 0;
    if (line_bad) begin
      if (is_term(b)) line_bad = 0;
    end else if (line_q.size() == 0) begin
      if (is_letter(b)) line_q.push_back(b);
      else if (!(is_term(b) || b == 8'h20)) begin
        kind = 2; held_code = 0; line_bad = 1;
      end
    end else if (is_digit(b)) begin
      line_q.push_back(b);
      if (line_value() > MAX_VAL) begin
        kind = 2; held_code = 1; line_bad = 1; line_q.delete();
      end
    end else if (is_term(b)) begin
      if (line_q.size() == 1) begin
        kind = 2; held_code = 2;
      end else begin
        kind = 1;
        held_addr = (line_q[0] >= "a") ? 32'(line_q[0] - "a") : 32'(line_q[0] - "A");
        held_data = 32'(line_value());
      end
      line_q.delete();
    end else begin
      kind = 2; held_code = 0; line_bad = 1; line_q.delete();
    end
  endtask

  task automatic model_reset();
    line_q.delete();
    line_bad  = 0;
    held_addr = 0;
    held_data = 0;
    held_code = 0;
  endtask

  task automatic check_held(input string tag);
    checkOutput({tag, "_addr"}, 32'(bus.wr_addr_out), held_addr);
    checkOutput({tag, "_data"}, 32'(bus.wr_data_out), held_data);
    checkOutput({tag, "_code"}, 32'(bus.err_code_out), held_code);
  endtask

  // Called at a negedge; drives one byte, checks its result, then idles 'gap' cycles
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int kind;
    bus.din     = b;
    bus.dval_in = 1'b1;
    model_byte(b, kind);
    @(posedge clk);
    @(negedge clk);
    bus.dval_in = 1'b0;
    checkOutput("wr_en", 32'(bus.wr_en_out), 32'(kind == 1));
    checkOutput("err", 32'(bus.err_out), 32'(kind == 2));
    check_held("byte");
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      checkOutput("quiet_wr", 32'(bus.wr_en_out), 0);
      checkOutput("quiet_err", 32'(bus.err_out), 0);
      if (i == 0) checkOutput("busy", 32'(bus.busy_out), 32'(model_busy()));
    end
  endtask

  task automatic send_string(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) applyStimulus(s[i], gap);
  endtask

  task automatic send_random_line();
    string s;
    string letters = "ABCDEFGHabcdefgh";
    longint v;
    int sel;
    int pos;
    s = "";
    if ($urandom_range(0, 4) == 0) s = " ";
    if ($urandom_range(0, 9) == 0) s = {s, "Z"};
    else s = {s, string'(letters[$urandom_range(0, 15)])};
    sel = $urandom_range(0, 9);
    case (sel)
      0:       v = MAX_VAL;
      1:       v = MAX_VAL + 1;
      2:       v = 0;
      3:       v = 99999;
      4:       v = -1;
      default: v = longint'($urandom_range(0, 65535));
    endcase
    if (v >= 0) begin
      if ($urandom_range(0, 3) == 0) s = {s, "00"};
      s = {s, $sformatf("%0d", v)};
    end
    if ($urandom_range(0, 6) == 0) begin
      pos = $urandom_range(0, s.len() - 1);
      s[pos] = 8'($urandom_range(0, 255));
    end
    s = {s, ($urandom_range(0, 1) == 1) ? "\r" : "\n"};
    for (int i = 0; i < s.len(); i++) applyStimulus(s[i], $urandom_range(0, 8));
  endtask

  initial begin
    bit early_err;
    int kind;
    bus.din     = 8'h00;
    bus.dval_in = 1'b0;
    model_reset();
    rst = 1'b1;
    #3 rst = 1'b0;
    #2;
    checkOutput("rst_wr_en", 32'(bus.wr_en_out), 0);
    checkOutput("rst_err", 32'(bus.err_out), 0);
    checkOutput("rst_busy", 32'(bus.busy_out), 0);
    check_held("rst");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    send_string("B192\n", 8);
    send_string("h65535\r", 8);
    send_string("A65536\n", 8);
    send_string("C7\n", 8);
    send_string("Z12\n", 8);
    send_string("E\n", 8);
    send_string("A007\r", 8);

    // Stalled command times out exactly TIMEOUT-1 cycles after the last byte
    send_string("D", 8);
    applyStimulus("4", 0);
    early_err = 0;
    for (int k = 1; k <= TIMEOUT - 2; k++) begin
      @(negedge clk);
      if (bus.err_out || bus.wr_en_out) early_err = 1;
    end
    checkOutput("timeout_early", 32'(early_err), 0);
    @(negedge clk);
    checkOutput("timeout_err", 32'(bus.err_out), 1);
    checkOutput("timeout_code", 32'(bus.err_code_out), 3);
    held_code = 3;
    line_q.delete();
    repeat (2) @(negedge clk);
    checkOutput("timeout_busy", 32'(bus.busy_out), 0);
    send_string("\n", 8);

    // Stalled bad line returns to idle without a second error
    send_string("Q1", 8);
    early_err = 0;
    repeat (TIMEOUT + 4) begin
      @(negedge clk);
      if (bus.err_out || bus.wr_en_out) early_err = 1;
    end
    checkOutput("discard_timeout_quiet", 32'(early_err), 0);
    line_bad = 0;
    checkOutput("discard_timeout_busy", 32'(bus.busy_out), 0);
    send_string("G5\n", 8);

    // Asynchronous reset in the middle of a command
    send_string("F12", 8);
    #2 rst = 1'b0;
    #1;
    model_reset();
    checkOutput("amid_busy", 32'(bus.busy_out), 0);
    checkOutput("amid_wr_en", 32'(bus.wr_en_out), 0);
    check_held("amid");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_string("\n", 8);
    send_string("F3\n", 8);

    // Back-to-back bytes, then idle spaces and terminators
    send_string("A1\r", 0);
    send_string(" \r \n  ", 0);
    applyStimulus("\n", 4);

    for (int n = 0; n < 300; n++) send_random_line();

    // Flush any unterminated model state cleanly before finishing
    applyStimulus("\n", 4);
    model_byte(8'h20, kind);
    checkOutput("final_busy", 32'(bus.busy_out), 32'(model_busy()));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
